// File: rtl/imm_pipe.sv
// Pipelined RISC-V immediate generator with a registered output stage and a
// one-entry skid buffer. Immediates are formed combinationally from the
// incoming instruction and captured on input transfer (latency 1).
module imm_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       extOp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    // Output stage registers
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_err_q, out_err_d;

    // Skid buffer registers
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_err_q, skid_err_d;

    // Immediate for the instruction currently offered
    logic [XLEN-1:0]  new_imm;
    logic             new_err;
    logic             in_xfer;

    assign in_ready = !skid_valid_q;
    assign in_xfer  = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_tag   = out_tag_q;
    assign out_err   = out_err_q;

    // Decode extOp into the extended immediate; 111 is the illegal format
    always_comb begin
        new_imm = '0;
        new_err = 1'b0;
        case (extOp)
            3'b000: new_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            3'b001: new_imm = {{(XLEN-20){instr[31]}}, instr[31:12]} << 12;
            3'b010: new_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            3'b011: new_imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
            3'b100: new_imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
            3'b101: new_imm = {{(XLEN-5){1'b0}}, instr[19:15]};
            3'b110: begin
                // RV64 shift amounts use one extra bit
                if (XLEN == 64) new_imm = {{(XLEN-6){1'b0}}, instr[25:20]};
                else            new_imm = {{(XLEN-5){1'b0}}, instr[24:20]};
            end
            default: begin
                new_imm = '0;
                new_err = 1'b1;
            end
        endcase
    end

    // Next-state for output stage and skid buffer; data regs untouched on flush
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                // in_ready was low, so no new entry can arrive this cycle
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                out_err_d    = skid_err_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_xfer;
                if (in_xfer) begin
                    out_imm_d = new_imm;
                    out_tag_d = in_tag;
                    out_err_d = new_err;
                end
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = new_imm;
            skid_tag_d   = in_tag;
            skid_err_d   = new_err;
        end
    end

    // State update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_imm_pipe.sv
// Directed bench for imm_pipe: format table on XLEN=32 and XLEN=64 instances
// sharing one stimulus, plus backpressure, flush and mid-stream reset sequences.
module tb_imm_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  extOp;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;
    logic [7:0]  out_tag32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [7:0]  out_tag64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .extOp(extOp), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
    );

    imm_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .extOp(extOp), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  op;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        err;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer an I-format entry whose immediate equals its tag
    task automatic offer(input logic [7:0] tag);
        in_valid = 1'b1;
        in_tag   = tag;
        instr    = {4'h0, tag, 20'h00093};
        extOp    = 3'b000;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] sent;
        int         got;

        vecs[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{32'h12345037, 3'b001, 32'h12345000, 64'h0000000012345000, 1'b0};
        vecs[2]  = '{32'hFE112E23, 3'b010, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[3]  = '{32'h0080006F, 3'b100, 32'h00000008, 64'h0000000000000008, 1'b0};
        vecs[4]  = '{32'h000FD073, 3'b101, 32'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[5]  = '{32'h03F00013, 3'b110, 32'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 64'h0000000000000000, 1'b1};
        vecs[7]  = '{32'h80000037, 3'b001, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[8]  = '{32'h80000063, 3'b011, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0};
        vecs[9]  = '{32'h00000F63, 3'b011, 32'h0000001E, 64'h000000000000001E, 1'b0};
        vecs[10] = '{32'h80000000, 3'b100, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; instr = 32'hFFF00093;
        extOp = 3'b000; in_tag = 8'hAA; out_ready = 1'b1;
        step(); step();
        check("reset out_valid", {63'b0, out_valid32}, 64'd0);
        check("reset out_imm", out_imm64, 64'd0);
        check("reset out_tag", {56'b0, out_tag32}, 64'd0);
        check("reset out_err", {63'b0, out_err32}, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        check("reset in_ready", {63'b0, in_ready32}, 64'd1);

        // Back-to-back format sweep, one entry per cycle
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            instr    = vecs[i].instr;
            extOp    = vecs[i].op;
            in_tag   = 8'(i + 20);
            check($sformatf("vec%0d in_ready", i), {63'b0, in_ready32}, 64'd1);
            step();
            check($sformatf("vec%0d out_valid", i), {62'b0, out_valid64, out_valid32}, 64'd3);
            check($sformatf("vec%0d imm32", i), {32'b0, out_imm32}, {32'b0, vecs[i].e32});
            check($sformatf("vec%0d imm64", i), out_imm64, vecs[i].e64);
            check($sformatf("vec%0d err", i), {62'b0, out_err64, out_err32},
                  {62'b0, vecs[i].err, vecs[i].err});
            check($sformatf("vec%0d tag", i), {56'b0, out_tag32}, 64'(i + 20));
        end
        in_valid = 1'b0;
        step();
        check("drain out_valid", {63'b0, out_valid32}, 64'd0);

        // Backpressure: tags 1..6, out_ready low in cycles 2..4
        sent = 8'd1; got = 0;
        for (int c = 1; c <= 30 && got < 6; c++) begin
            if (sent <= 8'd6) offer(sent);
            else in_valid = 1'b0;
            if (c == 3) instr = 32'hFFFFFFFF; // payload churn while blocked
            out_ready = !(c >= 2 && c <= 4);
            if (c == 3) check("bp in_ready low", {63'b0, in_ready32}, 64'd0);
            if (c >= 3 && c <= 5) begin
                check($sformatf("bp hold tag c%0d", c), {56'b0, out_tag32}, 64'd1);
                check($sformatf("bp hold valid c%0d", c), {63'b0, out_valid32}, 64'd1);
            end
            if (out_valid32 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp unexpected entry", {56'b0, out_tag32}, 64'hFF);
                end else begin
                    check($sformatf("bp tag %0d", got + 1), {56'b0, out_tag32},
                          {56'b0, exp_q[0]});
                    check($sformatf("bp imm %0d", got + 1), {32'b0, out_imm32},
                          {56'b0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready32) begin
                exp_q.push_back(sent);
                sent++;
            end
            step();
        end
        check("bp count", 64'(got), 64'd6);
        in_valid = 1'b0;
        check("bp empty after", {63'b0, out_valid32}, 64'd0);

        // Flush with output and skid both full, tag 9 offered alongside
        out_ready = 1'b0;
        offer(8'd7); step();
        offer(8'd8); step();
        check("fl skid full", {63'b0, in_ready32}, 64'd0);
        offer(8'd9); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl out_valid", {63'b0, out_valid32}, 64'd0);
        check("fl in_ready", {63'b0, in_ready32}, 64'd1);
        check("fl tag held", {56'b0, out_tag32}, 64'd7);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("fl no tag9 c%0d", c), {63'b0, out_valid32}, 64'd0);
        end
        // Flush while in_ready=1 also discards the offered entry
        offer(8'd10); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl2 out_valid", {63'b0, out_valid32}, 64'd0);

        // Mid-stream reset with skid full
        out_ready = 1'b0;
        offer(8'd11); step();
        offer(8'd12); step();
        offer(8'd14); rst = 1'b1; step();
        rst = 1'b0; in_valid = 1'b0;
        check("rst2 out_valid", {63'b0, out_valid32}, 64'd0);
        check("rst2 out_imm", {32'b0, out_imm32}, 64'd0);
        check("rst2 out_tag", {56'b0, out_tag32}, 64'd0);
        check("rst2 in_ready", {63'b0, in_ready32}, 64'd1);
        out_ready = 1'b1;
        offer(8'd13); step();
        in_valid = 1'b0;
        check("rst2 new valid", {63'b0, out_valid32}, 64'd1);
        check("rst2 new tag", {56'b0, out_tag32}, 64'd13);
        check("rst2 new imm", out_imm64, 64'd13);
        step();
        check("rst2 drained", {63'b0, out_valid32}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_pipe.md
Name: imm_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. Accepts instruction words with a format select and sideband tag over a valid/ready handshake. It returns the sign- or zero-extended immediate at XLEN width through a registered output stage backed by a one-entry skid buffer. It adds CSR-zimm and shift-amount formats and an illegal-format flag, and sits between fetch/decode and the execute operand mux.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
TAG_W, 8, width of the opaque sideband tag carried with each instruction (PC index, ROB id).

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  synchronous; discards all buffered entries.
in_valid  input  1  instr/extOp/in_tag valid.
in_ready  output  1  block can accept this cycle.
instr  input  32  raw RV instruction word.
extOp  input  3  immediate format select.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  out_imm/out_tag/out_err valid.
out_ready  input  1  consumer accepts this cycle.
out_imm  output  XLEN  extended immediate.
out_tag  output  TAG_W  tag of the entry on out_imm.
out_err  output  1  extOp was illegal for this entry.

Behaviour:
- Reset (rst=1 at edge): out_valid=0, skid empty, out_imm=0, out_tag=0, out_err=0. in_ready=1 from the first cycle after reset. Inputs are ignored while rst=1.
- Formats. Sign bit s=instr[31]. Every result is sign-extended to XLEN unless stated otherwise.
  - 000 I: instr[31:20].
  - 001 U: {instr[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
  - 010 S: {instr[31:25],instr[11:7]}.
  - 011 B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
  - 100 J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
  - 101 Z: zero-extended instr[19:15] (CSR uimm).
  - 110 SH: zero-extended instr[24:20] for XLEN=32; instr[25:20] for XLEN=64.
  - 111: out_imm=0, out_err=1.
  - Every other format gives out_err=0.
- Handshake:
  - Input transfer occurs when in_valid&in_ready.
  - Output transfer occurs when out_valid&out_ready.
  - in_ready = !skid_valid, driven directly from a register with no combinational path from out_ready.
  - out_* must hold stable while out_valid=1 and out_ready=0.
- Datapath: the immediate is computed combinationally from the inputs and captured on input transfer. Latency is 1 cycle: an entry accepted at edge N is presented on out_* after edge N when the output stage is free.
- Output stage / skid buffer, per edge:
  - Output stage empty or draining (!out_valid | out_ready):
    - skid holds an entry: skid moves to output; a new input may be accepted into skid only if in_ready was 1, which cannot happen here, so skid becomes empty.
    - skid empty: a new input, if any, loads the output stage; out_valid = input transfer.
  - Output stage stalled (out_valid & !out_ready): a new input transfer goes to skid; skid_valid=1, in_ready drops next cycle.
  - Throughput is one entry per cycle with out_ready held high.
  - Order is strictly preserved; no entry is dropped or duplicated.
- Flush: at the edge it clears out_valid and skid_valid. An input offered in the same cycle as flush is discarded. out_imm/out_tag/out_err hold their old values (don't-care while out_valid=0). flush has no effect on data registers.
- Simultaneous rst and flush: rst wins; same end state.
- Boundaries:
  - Skid full: in_ready=0 and in_valid is ignored.
  - out_ready=1 with out_valid=0 is legal and has no effect.
  - extOp/instr changing while in_valid=1 and in_ready=0 has no effect.

Test Plan:
- Reset/format sweep, XLEN=32, out_ready=1, one entry per cycle, each result one cycle after acceptance, out_err=0:
  - 0xFFF00093/000 -> 0xFFFFFFFF.
  - 0x12345037/001 -> 0x12345000.
  - 0xFE112E23/010 -> 0xFFFFFFFC.
  - 0x0080006F/100 -> 0x00000008.
- Z/SH/illegal: 0x000FD073/101 -> 0x0000001F. With XLEN=64, instr[25:20]=0x3F, extOp 110 -> 0x000000000000003F. Any instr with 111 -> out_imm=0, out_err=1.
- XLEN=64 sign extension: 0xFFF00093/000 -> 0xFFFFFFFFFFFFFFFF. 0x80000037/001 -> 0xFFFFFFFF80000000.
- Backpressure: stream tags 1..6 with out_ready=0 for cycles 2-4. in_ready falls after the second accept. The output shows tag 1 stable until released, then tags 1..6 appear in order with none lost.
- Flush: with output and skid both full, assert flush together with in_valid (tag 9). Next cycle out_valid=0 and in_ready=1. Tag 9 never appears.
- Mid-stream reset: rst for one cycle while the skid is full. Next cycle out_valid=0, out_imm=0, out_tag=0, in_ready=1. A new entry then completes with latency 1.
